// File: rtl/crc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : crc_seq_pkg
//  Purpose  : Shared definitions for the serial CRC transmit sequencer:
//             phase encoding, strobe bundle, and the helpers that size the
//             phase down-counter.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package crc_seq_pkg;

    // Sequencer phases. The numeric values are fixed so that the state
    // register can be carried as a plain 2-bit vector in the top level.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_DATA = 2'd1,
        SEQ_CRC  = 2'd2,
        SEQ_GAP  = 2'd3
    } seq_state_e;

    localparam int c_STATE_W = 2;

    // Moore strobes that depend only on the current phase.
    typedef struct packed {
        logic shift;
        logic crcen;
        logic select;
    } seq_strobes_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of the phase counter: must hold the largest reload value.
    // Never narrower than one bit so the counter stays a legal vector.
    function automatic int cnt_width(input int data_w, input int crc_w, input int gap);
        int w;
        w = clog2(max3(data_w, crc_w, gap) + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Strobe decode for the serial datapath.
    //   DATA : shift out data bits, LFSR absorbs them, mux on data
    //   CRC  : shift out check bits, LFSR frozen, mux on CRC
    //   IDLE / GAP : everything quiet
    function automatic seq_strobes_t state_strobes(input logic [c_STATE_W-1:0] st);
        seq_strobes_t s;
        s = '0;
        case (st)
            SEQ_DATA: begin
                s.shift = 1'b1;
                s.crcen = 1'b1;
            end
            SEQ_CRC: begin
                s.shift  = 1'b1;
                s.select = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_seq_bitcnt.sv
`default_nettype none
// ============================================================================
//  Module   : crc_seq_bitcnt
//  Purpose  : Loadable down-counter shared by the DATA, CRC and GAP phases.
//             Load has priority over decrement; the count saturates at zero
//             so it can never wrap.
//  Ports    : clk   - rising-edge clock
//             rst   - synchronous active-high reset (count -> 0)
//             load  - load 'value' into the counter
//             value - reload value
//             dec   - decrement by one (ignored when already zero)
//             zero  - count is zero
//  Revision : 1.0  initial release
// ============================================================================
module crc_seq_bitcnt
    import crc_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/crc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : crc_frame_sequencer
//  Purpose  : Control sequencer for the serial CRC transmit link. Accepts one
//             parallel word per frame (valid/ready) and strobes the external
//             shift register / CRC LFSR through DATA_W data bits, CRC_W check
//             bits and GAP idle cycles.
//  Options  : CRC_SEQ_ABORT_EN - adds the Abort input and Aborted output.
//  Ports    : CLK       - system clock, rising edge
//             CLR       - synchronous active-high reset
//             Enable    - permits starting new frames
//             din_valid - upstream word available
//             din_ready - word accepted this cycle (IDLE, Enable, not CLR)
//             Load      - parallel-load strobe (same cycle as handshake)
//             CrcClr    - clear CRC LFSR (same cycle as handshake)
//             Shift     - shift strobe, DATA and CRC phases
//             CrcEn     - LFSR absorbs serial bit, DATA phase
//             Select    - serial mux: 0 data, 1 CRC
//             Busy      - frame or gap in progress
//             Done      - one-cycle pulse after the last CRC bit
//             Abort     - (option) abandon frame in progress
//             Aborted   - (option) one-cycle pulse after an abort
//  Revision : 1.0  initial release
// ============================================================================
module crc_frame_sequencer
    import crc_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 4,
    parameter int GAP    = 1
) (
    input  logic CLK,
    input  logic CLR,
    input  logic Enable,
    input  logic din_valid,
`ifdef CRC_SEQ_ABORT_EN
    input  logic Abort,
    output logic Aborted,
`endif
    output logic din_ready,
    output logic Load,
    output logic CrcClr,
    output logic Shift,
    output logic CrcEn,
    output logic Select,
    output logic Busy,
    output logic Done
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [c_STATE_W-1:0] c_ST_IDLE = SEQ_IDLE;
    localparam logic [c_STATE_W-1:0] c_ST_DATA = SEQ_DATA;
    localparam logic [c_STATE_W-1:0] c_ST_CRC  = SEQ_CRC;
    localparam logic [c_STATE_W-1:0] c_ST_GAP  = SEQ_GAP;

    localparam int c_CNT_W = cnt_width(DATA_W, CRC_W, GAP);

    // Each phase lasts (reload + 1) cycles: the counter is loaded on entry
    // and the phase ends in the cycle where it reads zero.
    localparam logic [c_CNT_W-1:0] c_DATA_LD = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CRC_LD  = c_CNT_W'(CRC_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD  = (GAP > 0) ? c_CNT_W'(GAP - 1) : '0;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next;
    logic                 r_done;
    logic                 w_idle;
    logic                 w_hs;
    logic                 w_abort;
    logic                 w_frame_end;
    logic                 w_cnt_load;
    logic [c_CNT_W-1:0]   w_cnt_val;
    logic                 w_cnt_zero;
    seq_strobes_t         w_strobes;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_idle    = (r_state == c_ST_IDLE);

    // CLR is folded in so no word is consumed during a reset cycle.
    assign din_ready = w_idle & Enable & ~CLR;
    assign w_hs      = din_valid & din_ready;

    // Mealy strobes: the shift register loads and the LFSR clears in the
    // very cycle the word is accepted, so the first data bit can shift out
    // on the next cycle.
    assign Load   = w_hs;
    assign CrcClr = w_hs;

    // ------------------------------------------------------------------
    // Abort qualification (only meaningful while a frame is active)
    // ------------------------------------------------------------------
`ifdef CRC_SEQ_ABORT_EN
    assign w_abort = Abort & ~w_idle;
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and counter-reload logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_frame_end = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_hs) begin
                    w_next     = c_ST_DATA;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_DATA_LD;
                end
            end
            c_ST_DATA: begin
                if (w_cnt_zero) begin
                    w_next     = c_ST_CRC;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_CRC_LD;
                end
            end
            c_ST_CRC: begin
                if (w_cnt_zero) begin
                    // Last check bit leaves this cycle; Done is registered
                    // so it appears in the cycle after.
                    w_frame_end = 1'b1;
                    w_cnt_load  = 1'b1;
                    if (GAP > 0) begin
                        w_next    = c_ST_GAP;
                        w_cnt_val = c_GAP_LD;
                    end else begin
                        w_next    = c_ST_IDLE;
                        w_cnt_val = '0;
                    end
                end
            end
            c_ST_GAP: begin
                if (w_cnt_zero) begin
                    w_next     = c_ST_IDLE;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = '0;
                end
            end
            default: begin
                w_next     = c_ST_IDLE;
                w_cnt_load = 1'b1;
                w_cnt_val  = '0;
            end
        endcase

        // An abort overrides any phase transition, including the final
        // CRC cycle, so an aborted frame never reports Done.
        if (w_abort) begin
            w_next      = c_ST_IDLE;
            w_cnt_load  = 1'b1;
            w_cnt_val   = '0;
            w_frame_end = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Phase counter
    // ------------------------------------------------------------------
    crc_seq_bitcnt #(
        .WIDTH (c_CNT_W)
    ) u_bitcnt (
        .clk   (CLK),
        .rst   (CLR),
        .load  (w_cnt_load),
        .value (w_cnt_val),
        .dec   (~w_idle),
        .zero  (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // State and registered pulses
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= c_ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_frame_end;
        end
    end

`ifdef CRC_SEQ_ABORT_EN
    logic r_aborted;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort;
        end
    end

    assign Aborted = r_aborted;
`endif

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign w_strobes = state_strobes(r_state);
    assign Shift     = w_strobes.shift;
    assign CrcEn     = w_strobes.crcen;
    assign Select    = w_strobes.select;
    assign Busy      = ~w_idle;
    assign Done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_frame_sequencer
//  Purpose  : Self-checking bench for crc_frame_sequencer. Three instances:
//             u0 (8/4/1), u1 (8/4/0), u2 (1/1/0). Stimulus pushes expected
//             Load/Done/Aborted events; a monitor pops and compares them.
//  Options  : CRC_SEQ_ABORT_EN - also exercises Abort/Aborted on u0.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_crc_frame_sequencer;

    localparam int K_LOAD  = 0;
    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;

    typedef struct {
        int dut;
        int kind;
        int cyc;
        int nshift;
        int ncrc;
        int nsel;
        int fsel;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] clr, en, dv;
    logic [2:0] rdy, load, crcclr, shift, crcen, sel, busy, done;
`ifdef CRC_SEQ_ABORT_EN
    logic [2:0] abort, aborted;
`endif

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    int   n_shift[3];
    int   n_crc[3];
    int   n_sel[3];
    int   first_sel[3];

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    crc_frame_sequencer #(.DATA_W(8), .CRC_W(4), .GAP(1)) u0 (
        .CLK(clk), .CLR(clr[0]), .Enable(en[0]), .din_valid(dv[0]),
`ifdef CRC_SEQ_ABORT_EN
        .Abort(abort[0]), .Aborted(aborted[0]),
`endif
        .din_ready(rdy[0]), .Load(load[0]), .CrcClr(crcclr[0]), .Shift(shift[0]),
        .CrcEn(crcen[0]), .Select(sel[0]), .Busy(busy[0]), .Done(done[0])
    );

    crc_frame_sequencer #(.DATA_W(8), .CRC_W(4), .GAP(0)) u1 (
        .CLK(clk), .CLR(clr[1]), .Enable(en[1]), .din_valid(dv[1]),
`ifdef CRC_SEQ_ABORT_EN
        .Abort(abort[1]), .Aborted(aborted[1]),
`endif
        .din_ready(rdy[1]), .Load(load[1]), .CrcClr(crcclr[1]), .Shift(shift[1]),
        .CrcEn(crcen[1]), .Select(sel[1]), .Busy(busy[1]), .Done(done[1])
    );

    crc_frame_sequencer #(.DATA_W(1), .CRC_W(1), .GAP(0)) u2 (
        .CLK(clk), .CLR(clr[2]), .Enable(en[2]), .din_valid(dv[2]),
`ifdef CRC_SEQ_ABORT_EN
        .Abort(abort[2]), .Aborted(aborted[2]),
`endif
        .din_ready(rdy[2]), .Load(load[2]), .CrcClr(crcclr[2]), .Shift(shift[2]),
        .CrcEn(crcen[2]), .Select(sel[2]), .Busy(busy[2]), .Done(done[2])
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic string kname(input int k);
        case (k)
            K_LOAD:  return "Load";
            K_DONE:  return "Done";
            default: return "Aborted";
        endcase
    endfunction

    task automatic push_ev(input int d, input int k, input int c,
                           input int ns, input int nc, input int nsl, input int fs);
        ev_t e;
        e.dut = d; e.kind = k; e.cyc = c;
        e.nshift = ns; e.ncrc = nc; e.nsel = nsl; e.fsel = fs;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic pop_check(input int d, input int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected %s on u%0d at cycle %0d, nothing expected",
                     kname(k), d, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.dut != d || e.kind != k || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got %s u%0d cycle %0d want %s u%0d cycle %0d",
                     kname(k), d, cyc, kname(e.kind), e.dut, e.cyc);
        end
        if (k == K_LOAD) begin
            checks++;
            if (crcclr[d] !== 1'b1) begin
                errors++;
                $display("FAIL crcclr_with_load u%0d: got %b want 1", d, crcclr[d]);
            end
        end
        if (k == K_DONE) begin
            checks++;
            if (n_shift[d] != e.nshift || n_crc[d] != e.ncrc ||
                n_sel[d] != e.nsel || first_sel[d] != e.fsel) begin
                errors++;
                $display("FAIL frame_strobes u%0d: got shift/crcen/sel/firstsel %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         d, n_shift[d], n_crc[d], n_sel[d], first_sel[d],
                         e.nshift, e.ncrc, e.nsel, e.fsel);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    // ------------------------------------------------------------------
    // Monitor: counts strobes per frame, checks events against the queue
    // ------------------------------------------------------------------
    initial begin
        for (int d = 0; d < 3; d++) begin
            n_shift[d] = 0; n_crc[d] = 0; n_sel[d] = 0; first_sel[d] = -1;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (shift[d] === 1'b1) n_shift[d]++;
                if (crcen[d] === 1'b1) n_crc[d]++;
                if (sel[d] === 1'b1) begin
                    n_sel[d]++;
                    if (first_sel[d] < 0) first_sel[d] = cyc;
                end
                if (done[d] === 1'b1) pop_check(d, K_DONE);
`ifdef CRC_SEQ_ABORT_EN
                if (aborted[d] === 1'b1) pop_check(d, K_ABORT);
`endif
                if (load[d] === 1'b1) begin
                    pop_check(d, K_LOAD);
                    n_shift[d] = 0; n_crc[d] = 0; n_sel[d] = 0; first_sel[d] = -1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int c1;
        clr = 3'b111;
        en  = 3'b111;
        dv  = 3'b111;
`ifdef CRC_SEQ_ABORT_EN
        abort = 3'b000;
`endif
        // Reset: CLR held over two edges; valid/enable high must not leak.
        sample();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ready u%0d", d), rdy[d], 1'b0);
            chk($sformatf("reset_outs u%0d", d),
                {load[d], crcclr[d], shift[d], crcen[d], sel[d], busy[d], done[d]}, 7'b0);
        end
        step();
        clr = 3'b000;
        dv  = 3'b000;
        sample();
        chk("ready_after_reset u0", rdy[0], 1'b1);

        // ---- u0 basic frame (8/4/1) ----
        step();
        c0 = cyc;
        dv[0] = 1'b1;
        push_ev(0, K_LOAD, c0, 0, 0, 0, 0);
        push_ev(0, K_DONE, c0 + 13, 12, 8, 4, c0 + 9);
        step();
        dv[0] = 1'b0;
        wait_until(c0 + 5);
        sample();
        chk("data_phase u0", {busy[0], shift[0], crcen[0], sel[0]}, 4'b1110);
        wait_until(c0 + 10);
        sample();
        chk("crc_phase u0", {busy[0], shift[0], crcen[0], sel[0]}, 4'b1101);
        wait_until(c0 + 13);
        sample();
        chk("gap_not_ready u0", {rdy[0], busy[0], shift[0]}, 3'b010);
        step();
        sample();
        chk("ready_after_gap u0", {rdy[0], busy[0]}, 2'b10);

        // ---- u0 Enable dropped mid-frame ----
        step();
        c0 = cyc;
        dv[0] = 1'b1;
        push_ev(0, K_LOAD, c0, 0, 0, 0, 0);
        push_ev(0, K_DONE, c0 + 13, 12, 8, 4, c0 + 9);
        wait_until(c0 + 1);
        dv[0] = 1'b0;
        wait_until(c0 + 4);
        en[0] = 1'b0;
        dv[0] = 1'b1;
        wait_until(c0 + 20);
        sample();
        chk("enable_low_ready u0", rdy[0], 1'b0);
        step();
        dv[0] = 1'b0;
        step();
        en[0] = 1'b1;

        // ---- u0 CLR mid-frame, then a clean frame ----
        step();
        c0 = cyc;
        dv[0] = 1'b1;
        push_ev(0, K_LOAD, c0, 0, 0, 0, 0);
        step();
        dv[0] = 1'b0;
        wait_until(c0 + 6);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        sample();
        chk("after_clr u0", {shift[0], busy[0], done[0]}, 3'b000);
        wait_until(c0 + 20);
        c1 = cyc;
        dv[0] = 1'b1;
        push_ev(0, K_LOAD, c1, 0, 0, 0, 0);
        push_ev(0, K_DONE, c1 + 13, 12, 8, 4, c1 + 9);
        step();
        dv[0] = 1'b0;
        wait_until(c1 + 16);

        // ---- u1 back-to-back, GAP=0 ----
        step();
        c0 = cyc;
        dv[1] = 1'b1;
        push_ev(1, K_LOAD, c0, 0, 0, 0, 0);
        push_ev(1, K_DONE, c0 + 13, 12, 8, 4, c0 + 9);
        push_ev(1, K_LOAD, c0 + 13, 0, 0, 0, 0);
        push_ev(1, K_DONE, c0 + 26, 12, 8, 4, c0 + 22);
        push_ev(1, K_LOAD, c0 + 26, 0, 0, 0, 0);
        push_ev(1, K_DONE, c0 + 39, 12, 8, 4, c0 + 35);
        wait_until(c0 + 13);
        sample();
        chk("done_with_ready u1", {done[1], rdy[1], load[1]}, 3'b111);
        wait_until(c0 + 27);
        dv[1] = 1'b0;
        wait_until(c0 + 42);

        // ---- u2 minimum frame 1/1/0 ----
        step();
        c0 = cyc;
        dv[2] = 1'b1;
        push_ev(2, K_LOAD, c0, 0, 0, 0, 0);
        push_ev(2, K_DONE, c0 + 3, 2, 1, 1, c0 + 2);
        push_ev(2, K_LOAD, c0 + 3, 0, 0, 0, 0);
        push_ev(2, K_DONE, c0 + 6, 2, 1, 1, c0 + 5);
        wait_until(c0 + 1);
        sample();
        chk("min_data u2", {shift[2], crcen[2], sel[2]}, 3'b110);
        wait_until(c0 + 2);
        sample();
        chk("min_crc u2", {shift[2], crcen[2], sel[2]}, 3'b101);
        wait_until(c0 + 4);
        dv[2] = 1'b0;
        wait_until(c0 + 10);

`ifdef CRC_SEQ_ABORT_EN
        // ---- u0 abort in CRC phase ----
        step();
        c0 = cyc;
        dv[0] = 1'b1;
        push_ev(0, K_LOAD, c0, 0, 0, 0, 0);
        push_ev(0, K_ABORT, c0 + 11, 0, 0, 0, 0);
        step();
        dv[0] = 1'b0;
        wait_until(c0 + 10);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        sample();
        chk("after_abort u0", {rdy[0], busy[0], shift[0], done[0]}, 4'b1000);
        wait_until(c0 + 25);
`endif

        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
